sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences and shares the single parallel-port runtime SRAM among NUM_REQ on-chip requesters inside the microprocessor: core fetch/LSU, JTAG debug port, and the boot loader that copies EEPROM into RAM.
- Round-robin arbitration with an optional per-requester lock for bursts such as boot copy.
- Drives the SRAM pins (address, write, enable, data out/OE) and returns read data plus a completion pulse to the winning requester.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = boot loader, 1 = JTAG, 2 = core.
- ADDR_W, 16, SRAM word address width.
- DATA_W, 16, SRAM data width.

Ports:
- i_sysClk  input  1  system clock; all state on rising edge.
- i_sysRstn  input  1  asynchronous active-low reset.
- i_reqValid  input  NUM_REQ  per-requester access request.
- i_reqWr  input  NUM_REQ  1 = write, 0 = read.
- i_reqLock  input  NUM_REQ  holds ownership across consecutive accesses.
- i_reqAddr  input  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- i_reqData  input  NUM_REQ*DATA_W  packed write data.
- i_arbHold  input  1  pause: no new grants while high.
- o_reqGrant  output  NUM_REQ  one-hot, one-cycle request-accepted pulse.
- o_reqDone  output  NUM_REQ  one-hot, one-cycle access-complete pulse.
- o_rdData  output  DATA_W  read data; valid with o_reqDone, held until the next completed read.
- o_memAddr  output  ADDR_W  SRAM address.
- o_memWr  output  1  SRAM write select.
- o_memEn  output  1  SRAM chip enable.
- o_memDataOut  output  DATA_W  write data toward the pin.
- o_memDataOe  output  1  tri-state enable for the data pin driver.
- i_memData  input  DATA_W  data read from the pin.

Behaviour:
- Reset (async, while i_sysRstn = 0): all outputs 0, FSM = IDLE, lock owner cleared, rrPtr = NUM_REQ-1 so requester 0 wins first. Reset mid-access aborts immediately; o_memEn drops asynchronously.
- All outputs are registered.
- FSM states:
  - IDLE: arbitration occurs only here, and only when i_arbHold = 0.
    - Eligible set = i_reqValid, masked to the lock owner alone if a lock owner exists and its i_reqLock = 1.
    - Winner = first eligible index searching rrPtr+1, rrPtr+2, … with wrap modulo NUM_REQ.
    - On a win, at the clock edge: latch addr/wr/data; o_reqGrant[w] = 1; drive o_memAddr; o_memEn = 1; o_memWr = wr; o_memDataOut = data; o_memDataOe = wr; rrPtr = w; lock owner = w if i_reqLock[w] else none; next state = ACCESS.
    - With no eligible request, the memory outputs go to 0 (addr holds its last value).
  - ACCESS: exactly one cycle; grant pulse visible during this cycle.
    - At the edge: if read, o_rdData <= i_memData.
    - o_reqDone[w] = 1; o_memEn, o_memWr, o_memDataOe <= 0; next state = IDLE.
    - o_reqDone is visible during the following IDLE cycle.
- Throughput: one access per 2 cycles. Latency from valid sampled in IDLE: grant +1 cycle, done +2 cycles.
- Handshake: the requester holds valid/wr/addr/data stable until it sees the grant. It must deassert valid, or present a new request, in the cycle after the grant; the arbiter ignores inputs during ACCESS.
- Lock:
  - The owner is re-eligible exclusively while its i_reqLock = 1.
  - The lock is released in any IDLE cycle where the owner's i_reqLock = 0.
  - If the owner's valid = 0 but lock = 1, no grant is issued (the bus is held idle).
- i_arbHold asserted during ACCESS: the current access completes normally; afterward no grant until hold drops. Lock ownership is kept.
- Simultaneous requests: round-robin only, with no fixed priority beyond the reset pointer.
- Back-to-back requests from the same requester without lock: it is granted again only after the other valid requesters in round-robin order.
- Never more than one bit set in o_reqGrant or o_reqDone. o_memDataOe = 1 only when o_memWr = 1 and o_memEn = 1.

Decomposition:
- Shared package: ARB_STATE_T enum {ARB_IDLE, ARB_ACCESS}; constants REQ_BOOT = 0, REQ_JTAG = 1, REQ_CORE = 2; SRAM_ADDR_W = 16; SRAM_DATA_W = 16.
- One sub-module, rr_picker: combinational round-robin search (eligible vector + rrPtr → one-hot winner + found flag). The FSM, latches and lock owner stay in sram_arbiter.

Test Plan:
- Reset/first grant: release reset, assert valid[2] read at 0x0040 with i_memData = 0xBEEF. Required: grant[2] at +1, o_memEn = 1, o_memAddr = 0x0040, o_memWr = 0; done[2] at +2 with o_rdData = 0xBEEF.
- Write path: valid[1] write 0x1234 to 0x00FF. Required: in the ACCESS cycle o_memWr = 1, o_memDataOe = 1, o_memDataOut = 0x1234; all three are 0 in the next cycle.
- Round-robin: all three valid continuously from reset. Required: grant order 0, 1, 2, 0, 1, 2, one grant every 2 cycles, one-hot always.
- Lock burst: requester 0 with lock = 1 issues 4 reads to 0x0000–0x0003 while 1 and 2 stay valid. Required: 4 consecutive grants to 0; after lock drops, next grant goes to 1.
- Hold: assert i_arbHold during ACCESS of requester 2. Required: done[2] still pulses; no grant while held; grant resumes 1 cycle after hold drops.
- Async reset mid-ACCESS: drop i_sysRstn during a write. Required: o_memEn, o_memWr and o_memDataOe go to 0 without a clock edge; no done pulse; after release, requester 0 wins first.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and constants for the runtime SRAM arbiter
package sram_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_ACCESS
    } arb_state_t;

    localparam int REQ_BOOT    = 0;
    localparam int REQ_JTAG    = 1;
    localparam int REQ_CORE    = 2;
    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// rtl/sram_arbiter_rr_picker.sv - combinational round-robin winner search
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   win_idx,
    output logic               found
);

    // Scan from the farthest slot back to rr_ptr+1 so the nearest eligible index is written last.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (eligible[(int'(rr_ptr) + i) % NUM_REQ]) begin
                winner = '0;
                winner[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
                win_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter with burst lock for the shared runtime SRAM
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W
) (
    input  logic                      i_sysClk,
    input  logic                      i_sysRstn,
    input  logic [NUM_REQ-1:0]        i_reqValid,
    input  logic [NUM_REQ-1:0]        i_reqWr,
    input  logic [NUM_REQ-1:0]        i_reqLock,
    input  logic [NUM_REQ*ADDR_W-1:0] i_reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] i_reqData,
    input  logic                      i_arbHold,
    output logic [NUM_REQ-1:0]        o_reqGrant,
    output logic [NUM_REQ-1:0]        o_reqDone,
    output logic [DATA_W-1:0]         o_rdData,
    output logic [ADDR_W-1:0]         o_memAddr,
    output logic                      o_memWr,
    output logic                      o_memEn,
    output logic [DATA_W-1:0]         o_memDataOut,
    output logic                      o_memDataOe,
    input  logic [DATA_W-1:0]         i_memData
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   lock_idx;
    logic               lock_vld;
    logic               owner_locked;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   win_idx;
    logic               found;

    assign owner_locked = lock_vld && i_reqLock[lock_idx];

    // A locked owner shuts everyone else out, even while its own valid is low.
    always_comb begin
        eligible = i_reqValid;
        if (owner_locked) begin
            eligible           = '0;
            eligible[lock_idx] = i_reqValid[lock_idx];
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .win_idx  (win_idx),
        .found    (found)
    );

    // rr_ptr always equals the owner of the access in flight, so it doubles as the done index.
    always_ff @(posedge i_sysClk or negedge i_sysRstn) begin
        if (!i_sysRstn) begin
            state        <= ARB_IDLE;
            rr_ptr       <= PTR_W'(NUM_REQ - 1);
            lock_idx     <= '0;
            lock_vld     <= 1'b0;
            o_reqGrant   <= '0;
            o_reqDone    <= '0;
            o_rdData     <= '0;
            o_memAddr    <= '0;
            o_memWr      <= 1'b0;
            o_memEn      <= 1'b0;
            o_memDataOut <= '0;
            o_memDataOe  <= 1'b0;
        end else begin
            o_reqGrant <= '0;
            o_reqDone  <= '0;
            case (state)
                ARB_IDLE: begin
                    if (lock_vld && !i_reqLock[lock_idx]) begin
                        lock_vld <= 1'b0;
                    end
                    if (!i_arbHold && found) begin
                        state        <= ARB_ACCESS;
                        rr_ptr       <= win_idx;
                        lock_idx     <= win_idx;
                        lock_vld     <= i_reqLock[win_idx];
                        o_reqGrant   <= winner;
                        o_memAddr    <= i_reqAddr[int'(win_idx)*ADDR_W +: ADDR_W];
                        o_memEn      <= 1'b1;
                        o_memWr      <= i_reqWr[win_idx];
                        o_memDataOut <= i_reqData[int'(win_idx)*DATA_W +: DATA_W];
                        o_memDataOe  <= i_reqWr[win_idx];
                    end else begin
                        o_memEn      <= 1'b0;
                        o_memWr      <= 1'b0;
                        o_memDataOut <= '0;
                        o_memDataOe  <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    if (!o_memWr) begin
                        o_rdData <= i_memData;
                    end
                    o_reqDone[rr_ptr] <= 1'b1;
                    o_memEn           <= 1'b0;
                    o_memWr           <= 1'b0;
                    o_memDataOut      <= '0;
                    o_memDataOe       <= 1'b0;
                    state             <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_wr = '0;
    logic [2:0]  req_lock = '0;
    logic [47:0] req_addr = '0;
    logic [47:0] req_data = '0;
    logic        arb_hold = 1'b0;
    logic [15:0] mem_data = '0;
    logic [2:0]  req_grant;
    logic [2:0]  req_done;
    logic [15:0] rd_data;
    logic [15:0] mem_addr;
    logic        mem_wr;
    logic        mem_en;
    logic [15:0] mem_data_out;
    logic        mem_data_oe;

    int checks = 0;
    int failures = 0;

    sram_arbiter dut (
        .i_sysClk     (clk),
        .i_sysRstn    (rst_n),
        .i_reqValid   (req_valid),
        .i_reqWr      (req_wr),
        .i_reqLock    (req_lock),
        .i_reqAddr    (req_addr),
        .i_reqData    (req_data),
        .i_arbHold    (arb_hold),
        .o_reqGrant   (req_grant),
        .o_reqDone    (req_done),
        .o_rdData     (rd_data),
        .o_memAddr    (mem_addr),
        .o_memWr      (mem_wr),
        .o_memEn      (mem_en),
        .o_memDataOut (mem_data_out),
        .o_memDataOe  (mem_data_oe),
        .i_memData    (mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ($onehot0(req_grant) && $onehot0(req_done) &&
                    (!mem_data_oe || (mem_wr && mem_en))) else begin
                failures++;
                $error("FAIL invariant observed=g%b d%b oe%b wr%b en%b expected=onehot_oe_ok",
                       req_grant, req_done, mem_data_oe, mem_wr, mem_en);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_grant", 32'(req_grant), 32'h0);
        chk("rst_done", 32'(req_done), 32'h0);
        chk("rst_memen", 32'(mem_en), 32'h0);
        chk("rst_rddata", 32'(rd_data), 32'h0);
        rst_n = 1'b1;

        // First grant: core read at 0x0040
        req_valid = 3'b100;
        req_addr[2*16 +: 16] = 16'h0040;
        mem_data = 16'hBEEF;
        tick();
        chk("rd_grant", 32'(req_grant), 32'h4);
        chk("rd_memen", 32'(mem_en), 32'h1);
        chk("rd_addr", 32'(mem_addr), 32'h0040);
        chk("rd_memwr", 32'(mem_wr), 32'h0);
        chk("rd_oe", 32'(mem_data_oe), 32'h0);
        req_valid = 3'b000;
        tick();
        chk("rd_done", 32'(req_done), 32'h4);
        chk("rd_data", 32'(rd_data), 32'hBEEF);
        chk("rd_grant_clr", 32'(req_grant), 32'h0);
        chk("rd_memen_clr", 32'(mem_en), 32'h0);

        // Write path: JTAG writes 0x1234 to 0x00FF
        req_valid = 3'b010;
        req_wr = 3'b010;
        req_addr[1*16 +: 16] = 16'h00FF;
        req_data[1*16 +: 16] = 16'h1234;
        mem_data = 16'h0BAD;
        tick();
        chk("wr_grant", 32'(req_grant), 32'h2);
        chk("wr_memwr", 32'(mem_wr), 32'h1);
        chk("wr_oe", 32'(mem_data_oe), 32'h1);
        chk("wr_dout", 32'(mem_data_out), 32'h1234);
        chk("wr_addr", 32'(mem_addr), 32'h00FF);
        req_valid = 3'b000;
        req_wr = 3'b000;
        tick();
        chk("wr_done", 32'(req_done), 32'h2);
        chk("wr_memwr_clr", 32'(mem_wr), 32'h0);
        chk("wr_oe_clr", 32'(mem_data_oe), 32'h0);
        chk("wr_dout_clr", 32'(mem_data_out), 32'h0);
        chk("wr_rddata_held", 32'(rd_data), 32'hBEEF);

        // Round-robin from reset with all three requesting
        rst_n = 1'b0;
        tick();
        req_valid = 3'b111;
        req_addr = {16'h0300, 16'h0200, 16'h0100};
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_grant", 32'(req_grant), 32'(3'b001 << (i % 3)));
            chk("rr_addr", 32'(mem_addr), 32'h0100 * ((i % 3) + 1));
            tick();
            chk("rr_gap", 32'(req_grant), 32'h0);
            chk("rr_done", 32'(req_done), 32'(3'b001 << (i % 3)));
        end

        // Lock burst: boot loader reads 0..3 while others stay valid
        req_lock = 3'b001;
        for (int i = 0; i < 4; i++) begin
            req_addr[0 +: 16] = 16'(i);
            tick();
            chk("lk_grant", 32'(req_grant), 32'h1);
            chk("lk_addr", 32'(mem_addr), 32'(i));
            if (i == 3) begin
                req_lock = 3'b000;
                req_valid = 3'b110;
            end
            tick();
            chk("lk_done", 32'(req_done), 32'h1);
        end
        tick();
        chk("lk_release", 32'(req_grant), 32'h2);
        tick();
        chk("lk_release_done", 32'(req_done), 32'h2);

        // Hold raised during the core's access
        req_valid = 3'b100;
        tick();
        chk("hd_grant", 32'(req_grant), 32'h4);
        arb_hold = 1'b1;
        req_valid = 3'b011;
        tick();
        chk("hd_done", 32'(req_done), 32'h4);
        chk("hd_nogrant0", 32'(req_grant), 32'h0);
        tick();
        chk("hd_nogrant1", 32'(req_grant), 32'h0);
        chk("hd_memen", 32'(mem_en), 32'h0);
        tick();
        chk("hd_nogrant2", 32'(req_grant), 32'h0);
        arb_hold = 1'b0;
        tick();
        chk("hd_resume", 32'(req_grant), 32'h1);
        req_valid = 3'b000;
        tick();
        chk("hd_resume_done", 32'(req_done), 32'h1);

        // Async reset in the middle of a JTAG write
        req_valid = 3'b010;
        req_wr = 3'b010;
        req_addr[1*16 +: 16] = 16'h0ABC;
        req_data[1*16 +: 16] = 16'h5555;
        tick();
        chk("ar_grant", 32'(req_grant), 32'h2);
        chk("ar_memen_pre", 32'(mem_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_memen", 32'(mem_en), 32'h0);
        chk("ar_memwr", 32'(mem_wr), 32'h0);
        chk("ar_oe", 32'(mem_data_oe), 32'h0);
        tick();
        chk("ar_nodone", 32'(req_done), 32'h0);
        req_valid = 3'b111;
        req_wr = 3'b000;
        rst_n = 1'b1;
        tick();
        chk("ar_first", 32'(req_grant), 32'h1);
        tick();
        chk("ar_first_done", 32'(req_done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
